// File: rtl/shift_pkg.sv
// Shared types and helpers for the arith_shift_engine multi-cycle shifter.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_LSL = 3'd0,
    MODE_LSR = 3'd1,
    MODE_ASR = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Encodings 5..7 are reserved and must pass the operand through untouched.
  function automatic logic mode_is_valid(input logic [2:0] mode);
    return (mode <= 3'd4);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP positions; step 0 or a
// reserved mode passes the value through with a zero shift-out bit.
module shift_step import shift_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [AMT_W:0]   step,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             shift_bit
);

  logic signed [WIDTH-1:0] sval;
  logic [AMT_W:0]          inv_amt;
  logic [AMT_W-1:0]        stm1;
  logic [WIDTH-1:0]        rol_v;
  logic [WIDTH-1:0]        ror_v;

  always_comb begin
    sval      = value;
    inv_amt   = (AMT_W+1)'(WIDTH) - step;
    stm1      = step[AMT_W-1:0] - AMT_W'(1);
    rol_v     = (value << step) | (value >> inv_amt);
    ror_v     = (value >> step) | (value << inv_amt);
    result    = value;
    shift_bit = 1'b0;
    if (step != '0) begin
      case (mode)
        MODE_LSL: begin
          result    = value << step;
          shift_bit = value[inv_amt[AMT_W-1:0]];
        end
        MODE_LSR: begin
          result    = value >> step;
          shift_bit = value[stm1];
        end
        MODE_ASR: begin
          result    = sval >>> step;
          shift_bit = value[stm1];
        end
        MODE_ROL: begin
          result    = rol_v;
          shift_bit = rol_v[0];
        end
        MODE_ROR: begin
          result    = ror_v;
          shift_bit = ror_v[WIDTH-1];
        end
        default: begin
          result    = value;
          shift_bit = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arith_shift_engine.sv
// Multi-cycle shift/rotate engine: up to STEP positions per cycle, result held
// on a valid/ready output until the consumer takes it.
module arith_shift_engine import shift_pkg::*; #(
  parameter  int WIDTH = 64,
  parameter  int STEP  = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_shift_bit,
  output logic             out_err,
  output logic             busy
);

  localparam logic [AMT_W:0] STEP_L = (AMT_W+1)'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] rem_q;
  logic [2:0]       mode_q;
  logic             bit_q;
  logic             err_q;

  logic             accept;
  logic             cur_ok;
  logic [WIDTH-1:0] cur_val;
  logic [AMT_W-1:0] cur_rem;
  logic [2:0]       cur_mode;
  logic [AMT_W:0]   rem_ext;
  logic [AMT_W:0]   step;
  logic [AMT_W-1:0] rem_nxt;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  // The first step is taken on the accept edge straight from the inputs, so
  // an op of 1..STEP positions is ready one cycle after it is accepted.
  always_comb begin
    accept   = in_valid && (state_q == ST_IDLE);
    cur_val  = (state_q == ST_IDLE) ? in_data   : data_q;
    cur_rem  = (state_q == ST_IDLE) ? in_amount : rem_q;
    cur_mode = (state_q == ST_IDLE) ? in_mode   : mode_q;
    cur_ok   = mode_is_valid(cur_mode);
    rem_ext  = {1'b0, cur_rem};
    step     = '0;
    if (cur_ok) step = (rem_ext < STEP_L) ? rem_ext : STEP_L;
    rem_nxt  = cur_rem - step[AMT_W-1:0];
  end

  shift_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
    .value     (cur_val),
    .step      (step),
    .mode      (cur_mode),
    .result    (step_val),
    .shift_bit (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = (!cur_ok || rem_nxt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (rem_nxt == '0) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath is reset as well: the output bus must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      rem_q  <= '0;
      mode_q <= 3'd0;
      bit_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept || state_q == ST_SHIFT) begin
        data_q <= step_val;
        rem_q  <= rem_nxt;
        bit_q  <= step_bit;
      end
      if (accept) begin
        mode_q <= in_mode;
        err_q  <= !cur_ok;
      end
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign busy          = !in_ready;
  assign out_valid     = (state_q == ST_DONE);
  assign out_data      = data_q;
  assign out_shift_bit = bit_q;
  assign out_err       = err_q;

endmodule

// File: doc/arith_shift_engine.md
# arith_shift_engine

Parametrised multi-cycle shift/rotate engine for WIDTH-bit operands. Accepts an operand, shift amount and mode over a valid/ready handshake and shifts by up to STEP positions per cycle until the requested amount is consumed. Presents the result, the last bit shifted out and an error flag on a held output handshake. Successor to the fixed 64-bit, fixed-amount load/enable shifter; sits on the datapath wherever a variable-distance shift is needed without a full single-cycle barrel shifter.

## Interface
- WIDTH, 64, operand width; power of two, >= 8
- STEP, 8, maximum shift distance per cycle; power of two, 1..WIDTH
- AMT_W, $clog2(WIDTH), amount width (derived, not overridden)

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  engine idle, can accept
- in_data  in  WIDTH  operand
- in_amount  in  AMT_W  shift distance, 0..WIDTH-1
- in_mode  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5-7 reserved
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_shift_bit  out  1  last bit shifted/rotated out
- out_err  out  1  reserved mode requested
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE); busy = !in_ready.
- IDLE: on in_valid && in_ready, latch data, amount (as remaining), mode; clear shift bit. Go SHIFT if amount != 0 and mode valid, else DONE.
- Reserved mode: no shift, out_data = in_data, out_err = 1, out_shift_bit = 0.
- SHIFT: each cycle step = min(remaining, STEP); apply step under mode; remaining -= step; record bit last shifted out. Go DONE when remaining reaches 0.
- Per-mode step: LSL zero-fill at LSB; LSR zero-fill at MSB; ASR replicate MSB; ROL/ROR rotate.
- out_shift_bit: LSL = bit WIDTH-step of pre-step value; LSR/ASR = bit step-1; ROL = result LSB; ROR = result MSB; amount 0 -> 0.
- DONE: out_valid = 1; out_data, out_shift_bit, out_err stable. On out_ready go IDLE.
- in_valid outside IDLE ignored; no request queuing.

## Timing
- Reset (async assert, sync release): state IDLE, out_valid 0, out_data 0, out_shift_bit 0, out_err 0, busy 0, in_ready 1.
- Latency from accept edge to out_valid visible: max(1, ceil(amount/STEP)) cycles.
- Result leaves on out_valid && out_ready edge; in_ready rises the following cycle (one bubble between ops).
- out_ready before out_valid has no effect.
- rst_n low mid-SHIFT or in DONE: operation discarded, outputs to reset values immediately.
- Amount never exceeds WIDTH-1 by width; no clamping required.

## Structure
- Package shift_pkg: shift_mode_e enum (LSL, LSR, ASR, ROL, ROR), state enum, mode-is-valid function.
- Sub-module shift_step: combinational, inputs value, step (0..STEP), mode; outputs shifted value and shift-out bit. Engine instantiates one copy; all sequencing stays in arith_shift_engine.

## Test plan
- WIDTH=64, STEP=8: LSL amount 1, data 0x8000_0000_0000_0001 -> out_data 0x0000_0000_0000_0002, out_shift_bit 1, out_valid 1 cycle after accept.
- ASR amount 20, data 0x8000_0000_0000_0000 -> out_data 0xFFFF_F800_0000_0000, out_shift_bit 0, 3 cycles (8+8+4).
- ROR amount 63, data 0x1 -> out_data 0x2, out_shift_bit 0, 8 cycles; busy high throughout, in_valid pulses ignored.
- LSR amount 4, data 0xF0, out_ready low 5 cycles -> out_data 0x0F held stable, out_valid held, in_ready 0; accepted on first out_ready, in_ready 1 next cycle.
- LSR amount 40, rst_n pulsed low during 2nd SHIFT cycle -> out_valid 0, out_data 0 without clock edge; next request LSL 8 of 0xFF returns 0xFF00.
- Mode 6, amount 5, data 0xA5 -> out_data 0xA5, out_err 1, latency 1; LSR amount 0 of 0xA5 -> 0xA5, out_err 0, out_shift_bit 0.
